// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC frame packer: frame record, word count, sync nibble.
package lpc_pkg;

  localparam int FRAME_WORDS = 13;
  localparam int NUM_COEF    = 11;
  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic [3:0] LAST_IDX    = 4'(FRAME_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } pack_state_t;

  typedef struct packed {
    logic                       voiced;
    logic [0:NUM_COEF-1][15:0]  a;
    logic [15:0]                freq_count;
    logic [7:0]                 seq;
  } lpc_frame_t;

  function automatic logic [15:0] header_word(input logic [3:0] sync, input lpc_frame_t f);
    return {sync, f.voiced, 3'b000, f.seq};
  endfunction

endpackage

// File: rtl/lpc_frame_mux.sv
// Selects one 16-bit stream word of a frame by word index; purely combinational,
// no handshake of its own.
module lpc_frame_mux
  import lpc_pkg::*;
#(
  parameter logic [3:0] SYNC = SYNC_NIBBLE
) (
  input  lpc_frame_t  frame,
  input  logic [3:0]  idx,
  output logic [15:0] word
);

  always_comb begin
    word = '0;
    if (idx == 4'd0) begin
      word = header_word(SYNC, frame);
    end else if (idx == LAST_IDX) begin
      word = frame.freq_count;
    end else begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (idx == 4'(i + 1)) word = frame.a[i];
      end
    end
  end

endmodule

// File: rtl/lpc_frame_packer.sv
// Packs encoder frames into 13-word streams, header one cycle after capture; out_d/out_v
// hold under out_ready=0, one frame buffered, further arrivals dropped and counted.
module lpc_frame_packer
  import lpc_pkg::*;
#(
  parameter logic [3:0] SYNC       = SYNC_NIBBLE,
  parameter int         HOLD_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_vout,
  input  logic        enc_voiced,
  input  logic [15:0] enc_a0,
  input  logic [15:0] enc_a1,
  input  logic [15:0] enc_a2,
  input  logic [15:0] enc_a3,
  input  logic [15:0] enc_a4,
  input  logic [15:0] enc_a5,
  input  logic [15:0] enc_a6,
  input  logic [15:0] enc_a7,
  input  logic [15:0] enc_a8,
  input  logic [15:0] enc_a9,
  input  logic [15:0] enc_a10,
  input  logic [15:0] enc_freq_count,
  output logic [15:0] out_d,
  output logic        out_v,
  input  logic        out_ready,
  output logic        frame_start,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  pack_state_t state, state_nxt;
  lpc_frame_t  active, active_nxt, pend, pend_nxt, in_frame;
  logic        pend_vld, pend_vld_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [7:0]  seq, seq_nxt;
  logic        overflow_nxt;
  logic [7:0]  drop_nxt;
  logic [15:0] word;
  logic        pend_full, xfer, last;

  // The header seq is taken from the counter at capture time, not at send time.
  always_comb begin
    in_frame.voiced     = enc_voiced;
    in_frame.a          = {enc_a0, enc_a1, enc_a2, enc_a3, enc_a4, enc_a5,
                           enc_a6, enc_a7, enc_a8, enc_a9, enc_a10};
    in_frame.freq_count = enc_freq_count;
    in_frame.seq        = seq;
  end

  assign pend_full = (pend_vld == HOLD_DEPTH[0]);
  assign xfer      = out_v & out_ready;
  assign last      = xfer && (idx == LAST_IDX);

  always_comb begin
    state_nxt    = state;
    active_nxt   = active;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    idx_nxt      = idx;
    seq_nxt      = seq;
    overflow_nxt = overflow;
    drop_nxt     = drop_count;
    case (state)
      IDLE: begin
        if (enc_vout) begin
          active_nxt = in_frame;
          idx_nxt    = 4'd0;
          seq_nxt    = seq + 8'd1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (xfer) idx_nxt = idx + 4'd1;
        if (last) begin
          idx_nxt = 4'd0;
          if (pend_full) begin
            active_nxt   = pend;
            pend_vld_nxt = 1'b0;
          end else if (enc_vout) begin
            active_nxt = in_frame;
            seq_nxt    = seq + 8'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        // A strobe meeting a full pending slot is lost even if that slot drains this cycle.
        if (enc_vout) begin
          if (pend_full) begin
            overflow_nxt = 1'b1;
            if (drop_count != 8'hFF) drop_nxt = drop_count + 8'd1;
          end else if (!last) begin
            pend_nxt     = in_frame;
            pend_vld_nxt = 1'b1;
            seq_nxt      = seq + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      active     <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      idx        <= 4'd0;
      seq        <= 8'd0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      active     <= active_nxt;
      pend       <= pend_nxt;
      pend_vld   <= pend_vld_nxt;
      idx        <= idx_nxt;
      seq        <= seq_nxt;
      overflow   <= overflow_nxt;
      drop_count <= drop_nxt;
    end
  end

  lpc_frame_mux #(.SYNC(SYNC)) u_mux (
    .frame (active),
    .idx   (idx),
    .word  (word)
  );

  assign out_v       = (state == SEND);
  assign out_d       = out_v ? word : 16'h0000;
  assign frame_start = out_v & (idx == 4'd0);

endmodule

// File: tb/tb_lpc_frame_packer.sv
// Directed scoreboard bench for lpc_frame_packer: expected words queued at stimulus, popped by a monitor.
module tb_lpc_frame_packer;

  typedef struct {
    logic [15:0] w;
    logic        fs;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_vout = 1'b0;
  logic        enc_voiced = 1'b0;
  logic [15:0] enc_a [0:10];
  logic [15:0] enc_freq_count = 16'h0;
  logic [15:0] out_d;
  logic        out_v;
  logic        out_ready = 1'b1;
  logic        frame_start;
  logic        overflow;
  logic [7:0]  drop_count;

  exp_t        q[$];
  logic [7:0]  exp_seq = 8'd0;
  int          errors = 0;
  int          checks = 0;
  bit          expect_follow = 1'b0;

  always #5 clk = ~clk;

  lpc_frame_packer dut (
    .clk            (clk),
    .rst            (rst),
    .enc_vout       (enc_vout),
    .enc_voiced     (enc_voiced),
    .enc_a0         (enc_a[0]),
    .enc_a1         (enc_a[1]),
    .enc_a2         (enc_a[2]),
    .enc_a3         (enc_a[3]),
    .enc_a4         (enc_a[4]),
    .enc_a5         (enc_a[5]),
    .enc_a6         (enc_a[6]),
    .enc_a7         (enc_a[7]),
    .enc_a8         (enc_a[8]),
    .enc_a9         (enc_a[9]),
    .enc_a10        (enc_a[10]),
    .enc_freq_count (enc_freq_count),
    .out_d          (out_d),
    .out_v          (out_v),
    .out_ready      (out_ready),
    .frame_start    (frame_start),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented word against the queue head; pops on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expect_follow = 1'b0;
      end else begin
        if (expect_follow) begin
          chk("no_gap_header", {31'b0, out_v}, 32'd1);
          expect_follow = 1'b0;
        end
        if (out_v) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h, expected no output at %0t", out_d, $time);
          end else begin
            e = q[0];
            chk("word", {16'b0, out_d}, {16'b0, e.w});
            chk("frame_start", {31'b0, frame_start}, {31'b0, e.fs});
            if (out_ready) begin
              void'(q.pop_front());
              if (e.last && q.size() > 0) expect_follow = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic drive_frame(input logic v, input logic [15:0] base,
                             input logic [15:0] fq, input bit accept);
    exp_t e;
    if (accept) begin
      e.w = {4'hA, v, 3'b000, exp_seq}; e.fs = 1'b1; e.last = 1'b0;
      q.push_back(e);
      for (int i = 0; i < 11; i++) begin
        e.w = base + 16'(i); e.fs = 1'b0; e.last = 1'b0;
        q.push_back(e);
      end
      e.w = fq; e.fs = 1'b0; e.last = 1'b1;
      q.push_back(e);
      exp_seq = exp_seq + 8'd1;
    end
    enc_voiced = v;
    for (int i = 0; i < 11; i++) enc_a[i] = base + 16'(i);
    enc_freq_count = fq;
    enc_vout = 1'b1;
    @(posedge clk); #1;
    enc_vout = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 200; c++) begin
      if (q.size() == 0 && !out_v) break;
      @(posedge clk); #1;
    end
    chk({name, "_drained"}, q.size(), 32'd0);
    chk({name, "_out_v_low"}, {31'b0, out_v}, 32'd0);
  endtask

  // A strobe held during reset must be ignored.
  task automatic do_reset();
    rst = 1'b1;
    enc_vout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    enc_vout = 1'b0;
    q.delete();
    exp_seq = 8'd0;
    chk("rst_out_v", {31'b0, out_v}, 32'd0);
    chk("rst_out_d", {16'b0, out_d}, 32'd0);
    chk("rst_frame_start", {31'b0, frame_start}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_drop_count", {24'b0, drop_count}, 32'd0);
    @(posedge clk); #1;
    chk("rst_strobe_ignored", {31'b0, out_v}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 11; i++) enc_a[i] = 16'h0;
    do_reset();

    // 1: single frame, header on the cycle after the strobe
    drive_frame(1'b1, 16'h0100, 16'h0050, 1'b1);
    chk("t1_first_out_v", {31'b0, out_v}, 32'd1);
    chk("t1_first_word", {16'b0, out_d}, 32'h0000A800);
    chk("t1_first_fs", {31'b0, frame_start}, 32'd1);
    wait_idle("t1");

    // 2: alternating backpressure
    drive_frame(1'b1, 16'h0100, 16'h0050, 1'b1);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("t2");

    // 3: second strobe three cycles after the first
    do_reset();
    drive_frame(1'b1, 16'h1000, 16'h0123, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    drive_frame(1'b0, 16'h2000, 16'h0456, 1'b1);
    wait_idle("t3");
    chk("t3_overflow", {31'b0, overflow}, 32'd0);

    // 5: strobe coincides with the w12 transfer
    drive_frame(1'b0, 16'h3000, 16'h0777, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("t5_w12_aligned", {16'b0, out_d}, 32'h00000777);
    drive_frame(1'b1, 16'h4000, 16'h0888, 1'b1);
    wait_idle("t5");
    chk("t5_overflow", {31'b0, overflow}, 32'd0);
    chk("t5_drop_count", {24'b0, drop_count}, 32'd0);

    // 4: three consecutive strobes, third dropped
    do_reset();
    drive_frame(1'b1, 16'h5000, 16'h0011, 1'b1);
    drive_frame(1'b0, 16'h6000, 16'h0022, 1'b1);
    drive_frame(1'b1, 16'h7000, 16'h0033, 1'b0);
    wait_idle("t4");
    chk("t4_overflow", {31'b0, overflow}, 32'd1);
    chk("t4_drop_count", {24'b0, drop_count}, 32'd1);
    drive_frame(1'b1, 16'h8000, 16'h0044, 1'b1);
    wait_idle("t4b");
    chk("t4_overflow_sticky", {31'b0, overflow}, 32'd1);

    // 6: reset while w5 is on the bus
    drive_frame(1'b0, 16'h9000, 16'h0055, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_w5_before_rst", {16'b0, out_d}, 32'h00009004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_seq = 8'd0;
    chk("t6_out_v_after_rst", {31'b0, out_v}, 32'd0);
    chk("t6_overflow", {31'b0, overflow}, 32'd0);
    chk("t6_drop_count", {24'b0, drop_count}, 32'd0);
    drive_frame(1'b1, 16'hA000, 16'h0066, 1'b1);
    chk("t6_fresh_header", {16'b0, out_d}, 32'h0000A800);
    wait_idle("t6");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
